// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one asynchronous-read puzzle ROM among N_REQ clients.
// Optional lock keeps ownership; two-cycle accept-to-data read pipeline.
module rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [DATA_W-1:0]       rd_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [15:0]             grant_count,
  output logic                    idle
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0] NUM = (IDX_W + 1)'(N_REQ);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic              owner_vld;
  logic [IDX_W-1:0]  tag_idx;
  logic              tag_vld;
  logic [IDX_W-1:0]  win;
  logic              found;
  logic [IDX_W:0]    pos;
  logic              accept;
  logic [IDX_W-1:0]  nxt_ptr;
  logic [ADDR_W-1:0] win_addr;
  logic [N_REQ-1:0]  tag_oh;
  logic              owner_hold;

  assign owner_hold = owner_vld && req[owner];

  // A live owner wins outright; otherwise scan from rr_ptr with wrap.
  always_comb begin
    win   = '0;
    found = 1'b0;
    pos   = '0;
    if (owner_hold) begin
      win   = owner;
      found = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        pos = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
        if (pos >= NUM)
          pos = pos - NUM;
        if (!found && req[pos[IDX_W-1:0]]) begin
          win   = pos[IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
  end

  assign accept = rst_n && found;

  always_comb begin
    gnt = '0;
    if (accept)
      gnt[win] = 1'b1;
  end

  assign nxt_ptr  = (win == LAST) ? '0 : win + 1'b1;
  assign win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
    end else if (accept) begin
      rr_ptr    <= nxt_ptr;
      owner     <= win;
      owner_vld <= lock[win];
    end else if (owner_vld && !req[owner]) begin
      owner_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      tag_idx  <= '0;
      tag_vld  <= 1'b0;
    end else begin
      tag_vld <= accept;
      if (accept) begin
        rom_addr <= win_addr;
        tag_idx  <= win;
      end
    end
  end

  always_comb begin
    tag_oh = '0;
    tag_oh[tag_idx] = tag_vld;
  end

  // ROM output is valid one cycle after rom_addr loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      rd_valid <= tag_oh;
      if (tag_vld)
        rd_data <= rom_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      grant_count <= '0;
    else if (accept && grant_count != 16'hFFFF)
      grant_count <= grant_count + 16'd1;
  end

  assign idle = ~|req && !tag_vld && ~|rd_valid;

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized and directed bench for rom_arbiter.
// A transaction-level model predicts grants, read returns and counters.
module tb_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [DW-1:0]   rd_data;
  logic [N-1:0]    rd_valid;
  logic [15:0]     grant_count;
  logic            idle;

  logic [DW-1:0] rom [0:(1<<AW)-1];

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
    .req_addr(req_addr), .gnt(gnt), .rom_addr(rom_addr),
    .rom_data(rom_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .grant_count(grant_count), .idle(idle)
  );

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           q[$];
  int            m_ptr;
  bit            m_own_v;
  int            m_own;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  int            cyc;
  logic [N-1:0]  last_obs;
  int            checks;
  int            failures;

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (!rst_n) return g;
    if (m_own_v && req[m_own]) begin
      g[m_own] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req[j]) begin
        g[j] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_clear();
    q.delete();
    m_ptr   = 0;
    m_own_v = 0;
    m_own   = 0;
    m_cnt   = 0;
    m_addr  = '0;
    cyc     = 0;
  endtask

  task automatic set_addr(input int i);
    req_addr[i*AW +: AW] = AW'($urandom);
  endtask

  task automatic tick();
    logic [N-1:0]  eg;
    logic [N-1:0]  erv;
    logic [DW-1:0] erd;
    bit            eidle;
    bit            has_rd;
    int            w;
    eg = exp_gnt();
    #1;
    last_obs = gnt;
    checks++;
    if (gnt !== eg) begin
      failures++;
      $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, eg);
    end
    eidle  = (req == '0) && (q.size() == 0);
    has_rd = (q.size() > 0) && (q[0].due == cyc);
    erv = '0;
    erd = '0;
    if (has_rd) begin
      erv[q[0].idx] = 1'b1;
      erd = q[0].data;
      void'(q.pop_front());
    end
    checks++;
    if (rd_valid !== erv) begin
      failures++;
      $display("FAIL rd_valid cyc=%0d got=%b exp=%b", cyc, rd_valid, erv);
    end
    if (has_rd) begin
      checks++;
      if (rd_data !== erd) begin
        failures++;
        $display("FAIL rd_data cyc=%0d got=%h exp=%h", cyc, rd_data, erd);
      end
    end
    checks++;
    if (grant_count !== 16'(m_cnt)) begin
      failures++;
      $display("FAIL grant_count cyc=%0d got=%0d exp=%0d",
               cyc, grant_count, m_cnt);
    end
    checks++;
    if (rom_addr !== m_addr) begin
      failures++;
      $display("FAIL rom_addr cyc=%0d got=%h exp=%h", cyc, rom_addr, m_addr);
    end
    checks++;
    if (idle !== eidle) begin
      failures++;
      $display("FAIL idle cyc=%0d got=%b exp=%b", cyc, idle, eidle);
    end
    if (eg != '0) begin
      w = 0;
      for (int i = 0; i < N; i++)
        if (eg[i]) w = i;
      m_addr = req_addr[w*AW +: AW];
      q.push_back('{due: cyc + 2, idx: w, data: rom[m_addr]});
      if (m_cnt < 65535) m_cnt++;
      m_ptr   = (w + 1) % N;
      m_own_v = lock[w];
      m_own   = w;
    end else if (m_own_v && !req[m_own]) begin
      m_own_v = 0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    req  = '0;
    lock = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = N'($urandom_range(1, (1 << N) - 1));
    lock  = N'($urandom);
    for (int i = 0; i < N; i++) set_addr(i);
    #1;
    checks++;
    if (gnt !== '0) begin
      failures++;
      $display("FAIL rst_gnt got=%b exp=0", gnt);
    end
    checks++;
    if (rd_valid !== '0 || rd_data !== '0 || rom_addr !== '0 ||
        grant_count !== '0) begin
      failures++;
      $display("FAIL rst_outs got rv=%b rd=%h ra=%h gc=%0d exp all 0",
               rd_valid, rd_data, rom_addr, grant_count);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== '0) begin
      failures++;
      $display("FAIL rst_gnt_edge got=%b exp=0", gnt);
    end
    model_clear();
    rst_n = 1'b1;
    req   = '0;
    lock  = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    req  = 4'b0001;
    lock = '0;
    req_addr[0 +: AW] = 14'h0005;
    tick();
    checks++;
    if (last_obs !== 4'b0001) begin
      failures++;
      $display("FAIL single_gnt got=%b exp=0001", last_obs);
    end
    req = '0;
    tick();
    #1;
    checks++;
    if (rd_valid !== 4'b0001 || rd_data !== 8'h2A || grant_count !== 16'd1)
    begin
      failures++;
      $display("FAIL single_rd got rv=%b rd=%h gc=%0d exp 0001/2a/1",
               rd_valid, rd_data, grant_count);
    end
    drain(2);
  endtask

  task automatic test_rr_all();
    logic [N-1:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    req  = 4'b1111;
    lock = '0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) set_addr(i);
      tick();
      checks++;
      if (last_obs !== exp_seq[k]) begin
        failures++;
        $display("FAIL rr_order beat=%0d got=%b exp=%b",
                 k, last_obs, exp_seq[k]);
      end
    end
    drain(3);
  endtask

  task automatic test_lock();
    logic [N-1:0] exp_seq [6];
    int beats;
    exp_seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    req = 4'b0010;
    set_addr(1);
    tick();
    req   = 4'b1101;
    beats = 0;
    for (int i = 0; i < N; i++) set_addr(i);
    for (int k = 0; k < 6; k++) begin
      lock    = '0;
      lock[2] = (beats < 3);
      tick();
      checks++;
      if (last_obs !== exp_seq[k]) begin
        failures++;
        $display("FAIL lock_order beat=%0d got=%b exp=%b",
                 k, last_obs, exp_seq[k]);
      end
      if (last_obs[2]) begin
        beats++;
        set_addr(2);
        if (beats == 4) req[2] = 1'b0;
      end
      if (last_obs[3]) req[3] = 1'b0;
      if (last_obs[0]) req[0] = 1'b0;
    end
    drain(3);
  endtask

  task automatic test_owner_drop();
    apply_reset();
    req  = 4'b0010;
    lock = 4'b0010;
    set_addr(1);
    tick();
    req  = 4'b1001;
    lock = '0;
    set_addr(0);
    set_addr(3);
    tick();
    checks++;
    if (last_obs !== 4'b1000) begin
      failures++;
      $display("FAIL owner_drop got=%b exp=1000", last_obs);
    end
    req = 4'b0011;
    tick();
    checks++;
    if (last_obs !== 4'b0001) begin
      failures++;
      $display("FAIL owner_cleared got=%b exp=0001", last_obs);
    end
    req = 4'b0010;
    tick();
    drain(3);
  endtask

  task automatic test_reset_mid_beat();
    apply_reset();
    req = 4'b0100;
    set_addr(2);
    tick();
    rst_n = 1'b0;
    req   = '0;
    #1;
    checks++;
    if (rd_valid !== '0 || rd_data !== '0 || rom_addr !== '0 ||
        grant_count !== '0 || gnt !== '0) begin
      failures++;
      $display("FAIL midrst_outs got rv=%b rd=%h ra=%h gc=%0d g=%b exp 0",
               rd_valid, rd_data, rom_addr, grant_count, gnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd_valid !== '0) begin
      failures++;
      $display("FAIL midrst_pulse got=%b exp=0", rd_valid);
    end
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
    drain(3);
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_addr(i);
    tick();
    checks++;
    if (last_obs !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_first got=%b exp=0001", last_obs);
    end
    drain(3);
  endtask

  task automatic test_random();
    apply_reset();
    last_obs = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_obs[i] || !req[i]) begin
          req[i]  = ($urandom_range(0, 2) != 0);
          lock[i] = req[i] && ($urandom_range(0, 3) == 0);
          set_addr(i);
        end
      end
      tick();
    end
    drain(3);
  endtask

  task automatic test_saturate();
    apply_reset();
    req  = 4'b0001;
    lock = '0;
    for (int c = 0; c < 65537; c++) begin
      set_addr(0);
      tick();
    end
    #1;
    checks++;
    if (grant_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_count got=%h exp=ffff", grant_count);
    end
    for (int c = 0; c < 3; c++) tick();
    drain(3);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = '0;
    lock     = '0;
    req_addr = '0;
    last_obs = '0;
    model_clear();
    for (int a = 0; a < (1 << AW); a++) rom[a] = DW'($urandom);
    rom[5] = 8'h2A;
    @(negedge clk);
    test_reset();
    test_single();
    test_rr_all();
    test_lock();
    test_owner_drop();
    test_reset_mid_beat();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter ADDR_W, default 14: puzzle-ROM address width.
REQ-003 Parameter DATA_W, default 8: puzzle-ROM data width.
REQ-004 Port clk, input, 1: single clock, all state on rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port req, input, N_REQ: per-requester read request, held until granted.
REQ-007 Port lock, input, N_REQ: per-requester request to keep ownership after the current beat.
REQ-008 Port req_addr, input, N_REQ*ADDR_W: packed addresses; slice i belongs to requester i.
REQ-009 Port gnt, output, N_REQ: one-hot-or-zero combinational grant in the accept cycle.
REQ-010 Port rom_addr, output, ADDR_W: registered address to the asynchronous-read ROM.
REQ-011 Port rom_data, input, DATA_W: ROM read data, valid the cycle after rom_addr changes.
REQ-012 Port rd_data, output, DATA_W: registered read data returned to the winner.
REQ-013 Port rd_valid, output, N_REQ: one-hot one-cycle pulse identifying the owner of rd_data.
REQ-014 Port grant_count, output, 16: saturating count of accepted beats.
REQ-015 Port idle, output, 1: high when no beat is in flight and req is all zero.

Function
REQ-016 Handshake: a beat is accepted in cycle T when req[i] and gnt[i] are both high; the requester SHALL update req_addr/req/lock on that edge.
REQ-017 At most one gnt bit SHALL be high per cycle; gnt[i] SHALL never be high while req[i] is low.
REQ-018 Arbitration SHALL be round-robin: search starts at rr_ptr and wraps modulo N_REQ; the first requesting index wins.
REQ-019 After each accepted beat, rr_ptr SHALL become (winner+1) mod N_REQ.
REQ-020 Lock: an accepted beat with lock[i]=1 SHALL make i the owner; while owner is valid and req[owner]=1, only the owner SHALL be granted.
REQ-021 Ownership SHALL clear on an owner beat with lock=0, or in any cycle the owner drops req; other requesters SHALL then be arbitrated in that same cycle.
REQ-022 Pipeline: at the accept edge, rom_addr SHALL load the winner's address and a tag (winner index, valid) SHALL be registered.
REQ-023 At the next edge, rd_data SHALL capture rom_data and rd_valid[tag] SHALL pulse; read latency is 2 cycles from accept to visible data.
REQ-024 Back-to-back beats SHALL be supported: throughput one beat per cycle, including alternation between requesters.
REQ-025 rom_addr SHALL hold its value in cycles with no accept.
REQ-026 grant_count SHALL increment by 1 per accepted beat and hold at 16'hFFFF.
REQ-027 idle SHALL be combinational: req==0 and tag valid==0 and rd_valid==0.
REQ-028 No FSM beyond owner-valid flag, rr_ptr, and the 1-deep tag stage; no stalls or backpressure on rd_data.

Reset
REQ-029 On rst_n low, asynchronously: rom_addr=0, rd_data=0, rd_valid=0, grant_count=0, rr_ptr=0, owner invalid, tag invalid.
REQ-030 gnt SHALL be 0 while rst_n is low regardless of req.
REQ-031 Reset mid-beat SHALL discard in-flight data: no rd_valid pulse after release for beats accepted before reset.
REQ-032 First accept SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-033 Single requester: req=4'b0001, addr=0x0005 held one cycle, ROM[5]=0x2A -> gnt[0] in cycle T; rd_valid=4'b0001, rd_data=0x2A in T+2; grant_count=1.
REQ-034 All four requesting continuously, no lock -> grants 0,1,2,3,0 in consecutive cycles; rd_valid follows the same order two cycles later.
REQ-035 Requester 2 issues 4 beats with lock=1,1,1,0 while requesters 0 and 3 request -> four consecutive grants to 2, then 3, then 0.
REQ-036 Owner 1 with lock=1 drops req after one beat -> same cycle grant goes to next requesting index after 1; owner cleared.
REQ-037 rst_n asserted the cycle after an accept -> no rd_valid after release; all outputs 0; grant_count=0; first post-reset grant starts search at index 0.
REQ-038 Force 65 537 accepts -> grant_count saturates at 0xFFFF and stays there.
